// File: rtl/nios1_oci_dct_packer_if.sv
// Trace-record input and compressed-frame output bundle of the OCI DCT packer.
// The master side drives the records and the frame_ready acknowledge.
interface nios1_oci_dct_packer_if;
    logic        trace_enable;
    logic        rec_valid;
    logic [1:0]  rec_code;
    logic        end_trace;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        test_ending;
    logic        test_has_ended;

    modport master (
        output trace_enable, rec_valid, rec_code, end_trace, frame_ready,
        input  frame_valid, dct_buffer, dct_count, overflow, test_ending, test_has_ended
    );

    modport slave (
        input  trace_enable, rec_valid, rec_code, end_trace, frame_ready,
        output frame_valid, dct_buffer, dct_count, overflow, test_ending, test_has_ended
    );
endinterface

// File: rtl/nios1_oci_dct_packer.sv
// Packs 2-bit trace direction records into 30-bit frames behind a one-deep
// valid/ready output register, and sequences the end-of-test flush.
module nios1_oci_dct_packer #(
    parameter int unsigned MAX_RECORDS = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    nios1_oci_dct_packer_if.slave   bus
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_ENDED = 2'd2;
    localparam logic [3:0] MAX_CNT  = 4'(MAX_RECORDS);

    // Record i of a frame sits at bits [2i+1:2i].
    function automatic logic [29:0] slot_insert(input logic [29:0] base,
                                                input logic [3:0]  slot,
                                                input logic [1:0]  code);
        logic [29:0] res;
        res = base | ({28'd0, code} << {slot, 1'b0});
        return res;
    endfunction

    logic [1:0]  state_q,     state_d;
    logic [29:0] acc_q,       acc_d;
    logic [3:0]  acc_cnt_q,   acc_cnt_d;
    logic        overflow_q,  overflow_d;
    logic        ending_q,    ending_d;
    logic        ended_q,     ended_d;
    logic        out_valid_q;
    logic [29:0] out_buf_q;
    logic [3:0]  out_cnt_q;

    logic        rec_ok_s;
    logic        out_free_s;
    logic        load_s;
    logic [29:0] load_buf_s;
    logic [3:0]  load_cnt_s;
    logic [29:0] base_buf_s;
    logic [3:0]  base_cnt_s;
    logic [29:0] merged_buf_s;
    logic [3:0]  merged_cnt_s;

    assign rec_ok_s   = bus.rec_valid & bus.trace_enable & (bus.rec_code != 2'b00);
    assign out_free_s = ~out_valid_q | bus.frame_ready;

    // Accumulator, frame transfer, overflow and flush sequencing.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        overflow_d   = overflow_q;
        load_s       = 1'b0;
        load_buf_s   = 30'd0;
        load_cnt_s   = 4'd0;
        base_buf_s   = acc_q;
        base_cnt_s   = acc_cnt_q;
        merged_buf_s = 30'd0;
        merged_cnt_s = 4'd0;

        case (state_q)
            ST_RUN: begin
                // A full frame waiting on the output register moves first, so a
                // record in the same cycle lands in slot 0 of the emptied accumulator.
                if ((acc_cnt_q == MAX_CNT) && out_free_s) begin
                    load_s     = 1'b1;
                    load_buf_s = acc_q;
                    load_cnt_s = MAX_CNT;
                    base_buf_s = 30'd0;
                    base_cnt_s = 4'd0;
                end else begin
                    base_buf_s = acc_q;
                    base_cnt_s = acc_cnt_q;
                end

                if (rec_ok_s) begin
                    if (base_cnt_s != MAX_CNT) begin
                        merged_buf_s = slot_insert(base_buf_s, base_cnt_s, bus.rec_code);
                        merged_cnt_s = base_cnt_s + 4'd1;
                        if ((merged_cnt_s == MAX_CNT) && out_free_s && !load_s) begin
                            load_s     = 1'b1;
                            load_buf_s = merged_buf_s;
                            load_cnt_s = MAX_CNT;
                            acc_d      = 30'd0;
                            acc_cnt_d  = 4'd0;
                        end else begin
                            acc_d      = merged_buf_s;
                            acc_cnt_d  = merged_cnt_s;
                        end
                    end else begin
                        overflow_d = 1'b1;
                        acc_d      = base_buf_s;
                        acc_cnt_d  = base_cnt_s;
                    end
                end else begin
                    acc_d     = base_buf_s;
                    acc_cnt_d = base_cnt_s;
                end

                if (bus.end_trace) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_DRAIN: begin
                if (out_free_s) begin
                    if (acc_cnt_q != 4'd0) begin
                        load_s     = 1'b1;
                        load_buf_s = acc_q;
                        load_cnt_s = acc_cnt_q;
                        acc_d      = 30'd0;
                        acc_cnt_d  = 4'd0;
                    end else begin
                        state_d = ST_ENDED;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_ENDED: begin
                state_d = ST_ENDED;
            end

            default: begin
                state_d   = ST_RUN;
                acc_d     = 30'd0;
                acc_cnt_d = 4'd0;
            end
        endcase

        ending_d = (state_d != ST_RUN);
        ended_d  = (state_d == ST_ENDED);
    end

    // Control state, accumulator and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            acc_q      <= 30'd0;
            acc_cnt_q  <= 4'd0;
            overflow_q <= 1'b0;
            ending_q   <= 1'b0;
            ended_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            overflow_q <= overflow_d;
            ending_q   <= ending_d;
            ended_q    <= ended_d;
        end
    end

    // Output frame register: reload wins over the consumer's acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_buf_q   <= 30'd0;
            out_cnt_q   <= 4'd0;
        end else if (load_s) begin
            out_valid_q <= 1'b1;
            out_buf_q   <= load_buf_s;
            out_cnt_q   <= load_cnt_s;
        end else if (bus.frame_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.frame_valid    = out_valid_q;
    assign bus.dct_buffer     = out_buf_q;
    assign bus.dct_count      = out_cnt_q;
    assign bus.overflow       = overflow_q;
    assign bus.test_ending    = ending_q;
    assign bus.test_has_ended = ended_q;

endmodule

// File: tb/tb_nios1_oci_dct_packer.sv
// Directed bench for nios1_oci_dct_packer: a per-cycle vector table plus
// hand-written sequences for full-frame, back-pressure and reset corners.
module tb_nios1_oci_dct_packer;

    typedef struct {
        logic        rst;
        logic        ten;
        logic        rv;
        logic [1:0]  code;
        logic        et;
        logic        rdy;
        logic        fv;
        logic [29:0] dbuf;
        logic [3:0]  cnt;
        logic        ovf;
        logic        ending;
        logic        ended;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    vec_t tbl[$];

    nios1_oci_dct_packer_if bus();

    nios1_oci_dct_packer #(.MAX_RECORDS(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, ten, rv, input logic [1:0] code,
                                input logic et, rdy, fv, input logic [29:0] dbuf,
                                input logic [3:0] cnt, input logic ovf, ending, ended);
        vec_t v;
        v.rst = rst; v.ten = ten; v.rv = rv; v.code = code; v.et = et; v.rdy = rdy;
        v.fv = fv; v.dbuf = dbuf; v.cnt = cnt; v.ovf = ovf; v.ending = ending; v.ended = ended;
        return v;
    endfunction

    task automatic drive(input logic rst, ten, rv, input logic [1:0] code, input logic et, rdy);
        reset            = rst;
        bus.trace_enable = ten;
        bus.rec_valid    = rv;
        bus.rec_code     = code;
        bus.end_trace    = et;
        bus.frame_ready  = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input logic [29:0] b, input logic [3:0] c);
        chk({name, " fv"},  {31'd0, bus.frame_valid}, 32'd1);
        chk({name, " buf"}, {2'd0, bus.dct_buffer}, {2'd0, b});
        chk({name, " cnt"}, {28'd0, bus.dct_count}, {28'd0, c});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Power-on reset
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst fv",     {31'd0, bus.frame_valid},    32'd0);
        chk("rst buf",    {2'd0,  bus.dct_buffer},     32'd0);
        chk("rst cnt",    {28'd0, bus.dct_count},      32'd0);
        chk("rst ovf",    {31'd0, bus.overflow},       32'd0);
        chk("rst ending", {31'd0, bus.test_ending},    32'd0);
        chk("rst ended",  {31'd0, bus.test_has_ended}, 32'd0);

        // Full frame of taken records with consumer ready
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
            tick();
            if (i == 13) chk("full14 fv", {31'd0, bus.frame_valid}, 32'd0);
        end
        chk_frame("full15", 30'h2AAAAAAA, 4'd15);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        chk("full drained fv", {31'd0, bus.frame_valid}, 32'd0);

        // Back-pressure: 31 not-taken records with consumer stalled
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
            tick();
            if (i == 29) chk("bp30 ovf", {31'd0, bus.overflow}, 32'd0);
        end
        chk_frame("bp held", 30'h15555555, 4'd15);
        chk("bp31 ovf", {31'd0, bus.overflow}, 32'd1);
        // Transfer cycle carries a new record into slot 0
        drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
        tick();
        chk_frame("bp second", 30'h15555555, 4'd15);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        chk("bp second taken fv", {31'd0, bus.frame_valid}, 32'd0);
        chk("bp ovf sticky", {31'd0, bus.overflow}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        tick();
        chk("bp ending", {31'd0, bus.test_ending}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        chk_frame("bp slot0 flush", 30'h00000002, 4'd1);
        tick();
        chk("bp ended", {31'd0, bus.test_has_ended}, 32'd1);

        // Reset with a held frame and a 7-record partial
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, 1'b1, 1'b1, (i < 15) ? 2'b11 : 2'b01, 1'b0, 1'b0);
            tick();
        end
        chk_frame("pre-reset", 30'h3FFFFFFF, 4'd15);
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        chk("midrst fv",  {31'd0, bus.frame_valid}, 32'd0);
        chk("midrst buf", {2'd0,  bus.dct_buffer},  32'd0);
        chk("midrst cnt", {28'd0, bus.dct_count},   32'd0);
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
            tick();
        end
        chk_frame("post-reset", 30'h2AAAAAAA, 4'd15);

        // Per-cycle vectors: inputs applied, then outputs after the edge
        tbl.delete();
        // records 10,01,11 then flush with a stalled consumer
        tbl.push_back(mk(1,0,0,2'b00,0,0, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,1,2'b10,0,0, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,1,2'b01,0,0, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,1,2'b11,0,0, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,0,2'b00,1,0, 0,30'h0,4'd0,0,1,0));
        tbl.push_back(mk(0,1,0,2'b00,0,0, 1,30'h36,4'd3,0,1,0));
        tbl.push_back(mk(0,1,0,2'b00,0,0, 1,30'h36,4'd3,0,1,0));
        tbl.push_back(mk(0,1,0,2'b00,0,1, 0,30'h0,4'd0,0,1,1));
        tbl.push_back(mk(0,1,1,2'b10,1,1, 0,30'h0,4'd0,0,1,1));
        // no-op codes and disabled strobes interleaved with two real records
        tbl.push_back(mk(1,0,0,2'b00,0,1, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,1,2'b00,0,1, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,0,1,2'b01,0,1, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,1,2'b10,0,1, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,0,1,2'b11,0,1, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,0,2'b11,0,1, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,1,2'b11,0,1, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,0,2'b00,1,1, 0,30'h0,4'd0,0,1,0));
        tbl.push_back(mk(0,1,0,2'b00,0,1, 1,30'hE,4'd2,0,1,0));
        tbl.push_back(mk(0,1,0,2'b00,0,1, 0,30'h0,4'd0,0,1,1));
        // flush with nothing buffered: ended two cycles after end_trace
        tbl.push_back(mk(1,0,0,2'b00,0,1, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,0,2'b00,1,1, 0,30'h0,4'd0,0,1,0));
        tbl.push_back(mk(0,1,0,2'b00,0,1, 0,30'h0,4'd0,0,1,1));
        // record 11 alongside end_trace with two held; later records ignored
        tbl.push_back(mk(1,0,0,2'b00,0,0, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,1,2'b01,0,0, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,1,2'b10,0,0, 0,30'h0,4'd0,0,0,0));
        tbl.push_back(mk(0,1,1,2'b11,1,0, 0,30'h0,4'd0,0,1,0));
        tbl.push_back(mk(0,1,1,2'b10,0,0, 1,30'h39,4'd3,0,1,0));
        tbl.push_back(mk(0,1,1,2'b01,0,0, 1,30'h39,4'd3,0,1,0));
        tbl.push_back(mk(0,1,1,2'b01,0,1, 0,30'h0,4'd0,0,1,1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ten, tbl[i].rv, tbl[i].code, tbl[i].et, tbl[i].rdy);
            tick();
            chk($sformatf("row%0d fv", i),     {31'd0, bus.frame_valid},    {31'd0, tbl[i].fv});
            chk($sformatf("row%0d ovf", i),    {31'd0, bus.overflow},       {31'd0, tbl[i].ovf});
            chk($sformatf("row%0d ending", i), {31'd0, bus.test_ending},    {31'd0, tbl[i].ending});
            chk($sformatf("row%0d ended", i),  {31'd0, bus.test_has_ended}, {31'd0, tbl[i].ended});
            if (tbl[i].fv) begin
                chk($sformatf("row%0d buf", i), {2'd0, bus.dct_buffer}, {2'd0, tbl[i].dbuf});
                chk($sformatf("row%0d cnt", i), {28'd0, bus.dct_count}, {28'd0, tbl[i].cnt});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
